// File: rtl/debouncer_array_if.sv
// Button-panel bundle between the raw pins and the debounced control outputs.
// level is a steady state; press_pulse, release_pulse and sample_tick are single-clk strobes with no back-pressure.
interface debouncer_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] in_pulse;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic                sample_tick;

  modport master (
    output in_pulse,
    input  level, press_pulse, release_pulse, sample_tick
  );

  modport slave (
    input  in_pulse,
    output level, press_pulse, release_pulse, sample_tick
  );
endinterface

// File: rtl/debouncer_array.sv
// N-channel push-button debouncer: 2-FF sync, shared sample prescaler, per-channel
// stability filter with registered press/release strobes and optional auto-repeat.
module debouncer_array #(
  parameter int CHANNELS       = 4,
  parameter int CLK_DIV        = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_RATE    = 100
) (
  input logic               clk,
  input logic               rst,
  debouncer_array_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam int SW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_SAMPLES - 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [CHANNELS-1:0] IDLE_PIN = ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]       pre_cnt;
  logic [PW-1:0]       pre_next;
  logic                tick;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] sample;

  always_comb begin
    pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
  end

  // tick is registered so it is cleanly 0 during reset even when CLK_DIV is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_next;
      tick    <= (pre_next == PRE_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= bus.in_pulse;
      sync2 <= sync1;
    end
  end

  assign sample          = ACTIVE_LOW ? ~sync2 : sync2;
  assign bus.sample_tick = tick;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SW-1:0] stab_cnt;
    logic          lvl_q;
    logic          press_q;
    logic          rel_q;
    logic          changing;
    logic          rep_fire;

    assign changing = tick && (sample[i] != lvl_q) && (stab_cnt == STAB_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stab_cnt <= '0;
        lvl_q    <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (tick) begin
          if (sample[i] == lvl_q) begin
            stab_cnt <= '0;
          end else if (changing) begin
            lvl_q    <= sample[i];
            stab_cnt <= '0;
            press_q  <= sample[i];
            rel_q    <= ~sample[i];
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end
        if (rep_fire) begin
          press_q <= 1'b1;
        end
      end
    end

    if (REPEAT_DELAY > 0) begin : g_rep
      logic [RW-1:0] hold_cnt;
      logic [RW-1:0] hold_inc;
      logic [RW-1:0] hold_target;
      logic          repeating;

      assign hold_inc    = hold_cnt + RW'(1);
      assign hold_target = repeating ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      // a tick that completes a release must not also emit a repeat press
      assign rep_fire    = tick && lvl_q && !changing && (hold_inc == hold_target);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (!lvl_q || changing) begin
          hold_cnt  <= '0;
          repeating <= 1'b0;
        end else if (tick) begin
          if (hold_inc == hold_target) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
          end else begin
            hold_cnt <= hold_inc;
          end
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end

    assign bus.level[i]         = lvl_q;
    assign bus.press_pulse[i]   = press_q;
    assign bus.release_pulse[i] = rel_q;
  end

endmodule
